// File: rtl/write_back_unit.sv
`default_nettype none
// ============================================================================
// Module   : write_back_unit
// Purpose  : Formats load data, filters non-writing instructions and queues
//            register-file writes in a small FIFO with registered outputs.
// Revision : 1.0
// ============================================================================
module write_back_unit #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_reg,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_load,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [2:0]        in_addr_lo,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic [CNT_W-1:0]  count,
  output logic [15:0]       drop_cnt
);

  localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]   c_depth = CNT_W'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

  generate
    if (!((DATA_W == 32) || (DATA_W == 64))) begin : g_bad_data_w
      $error("write_back_unit: DATA_W must be 32 or 64");
    end
    if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
      $error("write_back_unit: DEPTH must be in 1..8");
    end
  endgenerate

  logic [REG_AW-1:0]  r_mem_reg  [DEPTH];
  logic [DATA_W-1:0]  r_mem_data [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_wr_en;
  logic [REG_AW-1:0]  r_wr_reg;
  logic [DATA_W-1:0]  r_wr_data;
  logic [15:0]        r_drop_cnt;

  logic               w_acc;
  logic               w_enq;
  logic               w_drop;
  logic               w_deq;
  logic [c_ptr_w-1:0] w_head_nxt;
  logic [c_ptr_w-1:0] w_tail_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [CNT_W-1:0]   w_remain;
  logic               w_wr_en_nxt;
  logic [REG_AW-1:0]  w_wr_reg_nxt;
  logic [DATA_W-1:0]  w_wr_data_nxt;

  logic [2:0]         w_off;
  logic [1:0]         w_size;
  logic               w_sx;
  logic [63:0]        w_ld64;
  logic [63:0]        w_sh;
  logic [63:0]        w_fmt64;
  logic [DATA_W-1:0]  w_wb_data;

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  // Load formatting is done in a 64-bit frame; bytes shifted in from above
  // the register width are zero before extension.
  assign w_off  = (DATA_W == 32) ? {1'b0, in_addr_lo[1:0]} : in_addr_lo;
  assign w_size = ((DATA_W == 32) && (in_size == 2'b11)) ? 2'b10 : in_size;
  assign w_sx   = ~in_unsigned;
  assign w_ld64 = 64'(in_load);
  assign w_sh   = w_ld64 >> {w_off, 3'b000};

  always_comb begin
    w_fmt64 = w_sh;
    case (w_size)
      2'b00:   w_fmt64 = {{56{w_sx & w_sh[7]}},  w_sh[7:0]};
      2'b01:   w_fmt64 = {{48{w_sx & w_sh[15]}}, w_sh[15:0]};
      2'b10:   w_fmt64 = {{32{w_sx & w_sh[31]}}, w_sh[31:0]};
      default: w_fmt64 = w_sh;
    endcase
  end

  assign w_wb_data = in_mem_to_reg ? w_fmt64[DATA_W-1:0] : in_result;

  assign in_ready = (r_count < c_depth);
  assign w_acc    = in_valid & in_ready;
  assign w_enq    = w_acc & in_reg_write & (in_reg != '0);
  assign w_drop   = w_acc & ~w_enq;
  assign w_deq    = r_wr_en & wr_ready;

  assign w_head_nxt  = w_deq ? f_inc(r_head) : r_head;
  assign w_tail_nxt  = w_enq ? f_inc(r_tail) : r_tail;
  assign w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
  assign w_remain    = r_count - CNT_W'(w_deq);

  // Output register tracks the head after this edge; when no older entry
  // survives the edge, the incoming instruction becomes the head directly.
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_reg_nxt  = r_wr_reg;
    w_wr_data_nxt = r_wr_data;
    if (w_count_nxt != '0) begin
      w_wr_en_nxt = 1'b1;
      if (w_remain == '0) begin
        w_wr_reg_nxt  = in_reg;
        w_wr_data_nxt = w_wb_data;
      end else begin
        w_wr_reg_nxt  = r_mem_reg[w_head_nxt];
        w_wr_data_nxt = r_mem_data[w_head_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_reg[r_tail]  <= in_reg;
      r_mem_data[r_tail] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_reg   <= '0;
      r_wr_data  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      r_count   <= w_count_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_reg  <= w_wr_reg_nxt;
      r_wr_data <= w_wr_data_nxt;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_reg   = r_wr_reg;
  assign wr_data  = r_wr_data;
  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
